// File: rtl/dna_pkg.sv
// Shared types for the nucleotide stream transmitter and motif tracker.
// Encoding A=00 C=01 G=10 T=11; detector motif is ACTG.
package dna_pkg;

   typedef logic [1:0] nt_t;

   localparam nt_t NT_A = 2'b00;
   localparam nt_t NT_C = 2'b01;
   localparam nt_t NT_G = 2'b10;
   localparam nt_t NT_T = 2'b11;

   localparam int MOTIF_LEN = 4;
   localparam logic [2*MOTIF_LEN-1:0] MOTIF = {NT_A, NT_C, NT_T, NT_G};

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      DONE
   } tx_state_t;

   typedef enum logic [1:0] {
      M_NONE,
      M_A,
      M_AC,
      M_ACT
   } trk_state_t;

   function automatic nt_t motif_nt(input int idx);
      return MOTIF[2*(MOTIF_LEN-1-idx) +: 2];
   endfunction

endpackage

// File: rtl/dna_motif_tracker.sv
// ACTG prefix tracker; used only when DNA_SEQ_TX_MOTIF_CNT_EN is defined.
// hit is combinational and qualified by en.
module dna_motif_tracker
   import dna_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  nt_t  nt,
   output logic hit
);

   trk_state_t st_q;
   trk_state_t st_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q <= M_NONE;
      end else begin
         st_q <= st_d;
      end
   end

   // No proper suffix of ACTG is a prefix, so a hit restarts from scratch.
   always_comb begin
      st_d = st_q;
      if (clr) begin
         st_d = M_NONE;
      end else if (en) begin
         if (nt == motif_nt(0)) begin
            st_d = M_A;
         end else begin
            unique case (st_q)
               M_A:     st_d = (nt == motif_nt(1)) ? M_AC : M_NONE;
               M_AC:    st_d = (nt == motif_nt(2)) ? M_ACT : M_NONE;
               M_ACT:   st_d = M_NONE;
               default: st_d = M_NONE;
            endcase
         end
      end
   end

   assign hit = en && !clr && (st_q == M_ACT) && (nt == motif_nt(3));

endmodule

// File: rtl/dna_seq_tx.sv
// Nucleotide stream transmitter: loads a packed sequence, sends it MSB-first.
// Define DNA_SEQ_TX_MOTIF_CNT_EN to add the motif_cnt output.
module dna_seq_tx
   import dna_pkg::*;
#(
   parameter int MAX_LEN = 16,
   parameter int LEN_W   = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [2*MAX_LEN-1:0] seq_data,
   input  logic [LEN_W-1:0]     seq_len,
   output logic                 busy,
   output logic [1:0]           dna_out,
   output logic                 dna_valid,
   input  logic                 dna_ready,
`ifdef DNA_SEQ_TX_MOTIF_CNT_EN
   output logic                 done,
   output logic [LEN_W-1:0]     motif_cnt
`else
   output logic                 done
`endif
);

   localparam int SW = 2 * MAX_LEN;
   localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

   tx_state_t        state_q;
   tx_state_t        state_d;
   logic [SW-1:0]    shreg_q;
   logic [SW-1:0]    shreg_d;
   logic [LEN_W-1:0] rem_q;
   logic [LEN_W-1:0] rem_d;
   logic             accept;
   logic             xfer;

   assign accept = (state_q == IDLE) && start;
   assign xfer   = (state_q == SEND) && dna_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         rem_q   <= rem_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      rem_d   = rem_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (seq_len != '0) begin
                  shreg_d = seq_data;
                  rem_d   = (seq_len > MAX_L) ? MAX_L : seq_len;
                  state_d = SEND;
               end else begin
                  state_d = DONE;
               end
            end
         end
         SEND: begin
            if (dna_ready) begin
               shreg_d = {shreg_q[SW-3:0], 2'b00};
               rem_d   = rem_q - 1'b1;
               if (rem_q == 1) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign dna_valid = (state_q == SEND);
   assign done      = (state_q == DONE);
   assign dna_out   = dna_valid ? shreg_q[SW-1 -: 2] : 2'b00;

`ifdef DNA_SEQ_TX_MOTIF_CNT_EN
   logic hit;

   dna_motif_tracker u_trk (
      .clk (clk),
      .rst (rst),
      .clr (accept),
      .en  (xfer),
      .nt  (dna_out),
      .hit (hit)
   );

   // Cleared on accepted start, saturating, held across done.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         motif_cnt <= '0;
      end else if (accept) begin
         motif_cnt <= '0;
      end else if (hit && (motif_cnt != '1)) begin
         motif_cnt <= motif_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_dna_seq_tx.sv
// Scoreboard bench for dna_seq_tx: driver queues expected nucleotides,
// a negedge monitor pops and compares on each handshake.
module tb_dna_seq_tx;

   localparam int MAX_LEN = 16;
   localparam int LEN_W   = 5;
   localparam int DW      = 2 * MAX_LEN;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic [DW-1:0]    seq_data = '0;
   logic [LEN_W-1:0] seq_len = '0;
   logic             dna_ready = 1'b0;
   logic             busy;
   logic [1:0]       dna_out;
   logic             dna_valid;
   logic             done;
`ifdef DNA_SEQ_TX_MOTIF_CNT_EN
   logic [LEN_W-1:0] motif_cnt;
`endif

   int checks = 0;
   int failures = 0;
   logic [1:0] exp_q[$];

   always #5 clk = ~clk;

   dna_seq_tx #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .seq_data  (seq_data),
      .seq_len   (seq_len),
      .busy      (busy),
      .dna_out   (dna_out),
      .dna_valid (dna_valid),
      .dna_ready (dna_ready),
`ifdef DNA_SEQ_TX_MOTIF_CNT_EN
      .done      (done),
      .motif_cnt (motif_cnt)
`else
      .done      (done)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic int eff_len(input int len);
      return (len > MAX_LEN) ? MAX_LEN : len;
   endfunction

   // Count ACTG windows (overlaps allowed) in the first n nucleotides.
   function automatic int motif_count(input logic [DW-1:0] d, input int n);
      logic [1:0] a[MAX_LEN];
      int c;
      c = 0;
      for (int i = 0; i < MAX_LEN; i++) a[i] = d[DW-1-2*i -: 2];
      for (int i = 0; i + 3 < n; i++)
         if ({a[i], a[i+1], a[i+2], a[i+3]} == 8'h1E) c++;
      return c;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         if (dna_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_valid actual=%0h required=none",
                        dna_out);
            end else begin
               chk("dna_out", {30'd0, dna_out}, {30'd0, exp_q[0]});
               if (dna_ready) void'(exp_q.pop_front());
            end
         end else begin
            chk("idle_dna_out", {30'd0, dna_out}, 32'd0);
         end
      end
   end

   task automatic send(input logic [DW-1:0] d, input int len,
                       input int ready_pct, input bit poke,
                       input logic [63:0] stall_mask);
      int n;
      int stalls;
      int cyc;
      bit seen;
      n = eff_len(len);
      @(posedge clk);
      #1;
      start = 1'b1;
      seq_data = d;
      seq_len = len[LEN_W-1:0];
      for (int i = 0; i < n; i++) exp_q.push_back(d[DW-1-2*i -: 2]);
      @(posedge clk);
      #1;
      start = 1'b0;
      seq_data = $urandom;
      seq_len = LEN_W'($urandom);
      cyc = 0;
      stalls = 0;
      seen = done;
      while (!seen && cyc < 200) begin
         chk("busy_active", {31'd0, busy}, 32'd1);
         start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
         dna_ready = ($urandom_range(0, 99) < ready_pct);
         if (cyc < 64 && stall_mask[cyc]) dna_ready = 1'b0;
         if (dna_valid && !dna_ready) stalls++;
         @(posedge clk);
         #1;
         cyc++;
         seen = done;
      end
      start = 1'b0;
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL done_timeout actual=none required=%0d", n + stalls);
      end else begin
         chk("done_latency", cyc, n + stalls);
      end
      chk("busy_at_done", {31'd0, busy}, 32'd1);
      chk("valid_at_done", {31'd0, dna_valid}, 32'd0);
`ifdef DNA_SEQ_TX_MOTIF_CNT_EN
      chk("motif_cnt", {27'd0, motif_cnt}, motif_count(d, n));
`endif
      @(posedge clk);
      #1;
      chk("done_width", {31'd0, done}, 32'd0);
      chk("busy_after_done", {31'd0, busy}, 32'd0);
      chk("queue_drained", exp_q.size(), 32'd0);
`ifdef DNA_SEQ_TX_MOTIF_CNT_EN
      chk("motif_hold", {27'd0, motif_cnt}, motif_count(d, n));
`endif
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_valid"}, {31'd0, dna_valid}, 32'd0);
      chk({tag, "_dna_out"}, {30'd0, dna_out}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
`ifdef DNA_SEQ_TX_MOTIF_CNT_EN
      chk({tag, "_motif"}, {27'd0, motif_cnt}, 32'd0);
`endif
   endtask

   task automatic reset_mid_send();
      @(posedge clk);
      #1;
      start = 1'b1;
      seq_data = 32'h1E1E_0000;
      seq_len = 5'd8;
      dna_ready = 1'b1;
      for (int i = 0; i < 8; i++) exp_q.push_back(seq_data[DW-1-2*i -: 2]);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      exp_q.delete();
      chk_reset_vals("async_rst");
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("rst_no_done", {31'd0, done}, 32'd0);
      end
      @(negedge clk);
      #2;
      rst = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("post_rst_idle", {31'd0, busy}, 32'd0);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [DW-1:0] d;
      #12;
      chk_reset_vals("reset");
      @(negedge clk);
      #2;
      rst = 1'b1;

      send(32'h1E00_0000, 4, 100, 1'b0, 64'h0);
      send(32'h1E00_0000, 4, 100, 1'b0, 64'hE);
      send(32'hFFFF_FFFF, 0, 100, 1'b0, 64'h0);
      send(32'h1234_5678, 20, 100, 1'b1, 64'h0);
      reset_mid_send();
      send(32'hC0FF_EE00, 8, 100, 1'b0, 64'h0);
      send(32'hDE1E_0000, 8, 100, 1'b0, 64'h0);
      send(32'h1E1E_1E00, 12, 100, 1'b0, 64'h0);

      for (int k = 0; k < 40; k++) begin
         d = $urandom;
         if ($urandom_range(0, 2) == 0) d[DW-1 -: 8] = 8'h1E;
         if ($urandom_range(0, 2) == 0) d[DW-7 -: 8] = 8'h1E;
         send(d, $urandom_range(0, 20), $urandom_range(30, 100),
              1'($urandom_range(0, 1)), 64'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
